seq_mult8_core: RTL
===================

# seq_mult8_core

Sequential 8x8 shift-add multiplier core that sits directly under the top-level user project wrapper's multiplier macro. The macro maps its operands, start strobe and product onto the Caravel-style user I/O pads. The core synchronizes an asynchronous pad-level start strobe and captures two 8-bit operands. It then computes the 16-bit product in 8 clock cycles and holds the result with a `done` flag until the next start.

## Interface
- `SYNC_STAGES`, 2: number of flops in the `start_i` synchronizer (≥2).
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-low (0 = reset).
- `start_i`  in  1  asynchronous pad-level start; a rising edge requests one multiply.
- `a_i`  in  8  multiplicand; must be stable from the start rising edge until the load edge.
- `b_i`  in  8  multiplier; same stability rule as `a_i`.
- `busy_o`  out  1  high while state is RUN.
- `done_o`  out  1  high while state is DONE.
- `product_o`  out  16  last completed product; held until the next completion.

## Operation
- Reset (`wb_rst_i`=0 at a clock edge):
  - state goes to IDLE; synchronizer, edge register, counter and datapath clear to 0.
  - `busy_o`=0, `done_o`=0, `product_o`=16'h0000.
- Start detection: `start_i` passes through `SYNC_STAGES` flops plus one history flop. The edge pulse is `sync_last & ~hist`, i.e. exactly one cycle per rising edge. Holding `start_i` high yields exactly one operation.
- States:
  - IDLE: on edge pulse, load operands and go to RUN.
  - RUN: executes 8 steps, with a 3-bit counter counting 0..7.
    - Each step: if `P[0]`, then `P[16:8] <= P[15:8] + mcand` (9-bit sum, carry kept); then `P >>= 1`.
    - After the step at count 7, write `product_o`, go to DONE, clear counter.
  - DONE: hold `product_o`. On edge pulse, reload operands and go to RUN; `done_o` drops on that edge.
- Datapath load: `mcand <= a_i`, `P[16:0] <= {9'b0, b_i}`.
- Edge pulse during RUN is discarded: no queueing, and operands are not re-sampled.
- `product_o` keeps its previous value throughout RUN. It changes only on the RUN→DONE edge.
- Reset mid-RUN aborts immediately. No partial result reaches `product_o`, which reads 0 after reset.

## Timing
- Edge 0 is the first clock edge that samples `start_i`=1.
- Edge pulse is high in the cycle after edge `SYNC_STAGES`-1.
- Operands are sampled at edge `SYNC_STAGES`, which is also the IDLE/DONE→RUN transition. With default parameters that is edge 2.
- RUN occupies 8 edges. `done_o`=1 and the new `product_o` are visible after edge `SYNC_STAGES`+8 (default: edge 10).
- `busy_o` and `done_o` are never both 1. Both are registered state decodes with no combinational path from inputs.
- Minimum spacing between accepted starts is 9 cycles plus the synchronizer latency.

## Configuration
- `MULT8_SIGNED_EN` defined: `a_i` and `b_i` are two's complement.
  - At load, magnitudes (|x|, with 8'h80 giving 128 unsigned) go into the datapath, and `neg = a_i[7] ^ b_i[7]` is registered.
  - On RUN→DONE, `product_o <= neg ? -P[15:0] : P[15:0]`.
  - Latency is unchanged.
- Not defined: operands are unsigned, `product_o <= P[15:0]`, and no `neg` register is instantiated.

## Structure
- Package `mult8_pkg`:
  - state enum `{IDLE, RUN, DONE}`;
  - constants `OP_W`=8, `PROD_W`=16, `STEPS`=8.
- Sub-module `start_sync_edge`:
  - parameter `SYNC_STAGES`;
  - ports `wb_clk_i`, `wb_rst_i`, `async_i`, `pulse_o`;
  - synchronous active-low reset clearing all flops.
- The core instantiates one `start_sync_edge`. FSM, counter and datapath stay in `seq_mult8_core`.

## Test plan
- Unsigned, a=8'hFF, b=8'hFF, one start pulse → `busy_o` for 8 cycles, then `done_o`=1 and `product_o`=16'hFE01 after edge 10.
- a=8'h00, b=8'h5A → `product_o`=16'h0000 with `done_o`=1. Then a=8'h0C, b=8'h0D restart from DONE → `done_o` drops for 8 cycles, then `product_o`=16'h009C.
- `start_i` held high for 40 cycles, a=8'h03, b=8'h05 → exactly one RUN period. `product_o`=16'h000F and `done_o` stays 1.
- Second `start_i` rise during RUN with changed a/b → ignored; the original product completes on schedule and no second RUN follows.
- `wb_rst_i`=0 for one cycle at RUN step 4 → next cycle `busy_o`=0, `done_o`=0, `product_o`=16'h0000, IDLE.
- With `MULT8_SIGNED_EN`:
  - a=8'h80, b=8'h80 → 16'h4000;
  - a=8'h80, b=8'h7F → 16'hC080;
  - a=8'hFF, b=8'h01 → 16'hFFFF.

Source files
------------

// File: rtl/mult8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// No logic; latency and backpressure are defined by the users of this package.
package mult8_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int STEPS  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement magnitude; 8'h80 maps to 128 read as unsigned.
   function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] x);
      return x[OP_W-1] ? -x : x;
   endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Synchronizes an async level and emits a one-cycle pulse per rising edge.
// Latency: pulse high in the cycle after edge SYNC_STAGES-1; no backpressure.
module start_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic async_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/seq_mult8_core.sv
// Sequential 8x8 shift-add multiplier; MULT8_SIGNED_EN selects two's-complement operands.
// Latency: product and done visible after edge SYNC_STAGES+8; starts during RUN are dropped.
module seq_mult8_core
   import mult8_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start_i,
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [PROD_W-1:0] product_o
);

   state_t              state_q, state_d;
   logic                start_pulse;
   logic                load;
   logic                last_step;
   logic [2:0]          cnt_q;
   logic [OP_W-1:0]     mcand_q;
   logic [PROD_W:0]     p_q;
   logic [PROD_W-1:0]   product_q;
   logic [OP_W:0]       sum;
   logic [PROD_W:0]     p_step;
   logic [OP_W-1:0]     a_ld, b_ld;
   logic [PROD_W-1:0]   result;

   start_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .async_i  (start_i),
      .pulse_o  (start_pulse)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   assign last_step = (cnt_q == 3'(STEPS - 1));

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_pulse) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN:     if (last_step) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // One shift-add step: conditional 9-bit add into the upper half, then shift right.
   always_comb begin
      sum    = {1'b0, p_q[PROD_W-1:OP_W]} + {1'b0, mcand_q};
      p_step = p_q[0] ? {1'b0, sum, p_q[OP_W-1:1]} : {1'b0, p_q[PROD_W:1]};
   end

`ifdef MULT8_SIGNED_EN
   logic neg_q;

   assign a_ld   = mag(a_i);
   assign b_ld   = mag(b_i);
   assign result = neg_q ? -p_step[PROD_W-1:0] : p_step[PROD_W-1:0];

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i)  neg_q <= 1'b0;
      else if (load)  neg_q <= a_i[OP_W-1] ^ b_i[OP_W-1];
   end
`else
   assign a_ld   = a_i;
   assign b_ld   = b_i;
   assign result = p_step[PROD_W-1:0];
`endif

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         cnt_q     <= '0;
         mcand_q   <= '0;
         p_q       <= '0;
         product_q <= '0;
      end else if (load) begin
         cnt_q   <= '0;
         mcand_q <= a_ld;
         p_q     <= {{(PROD_W + 1 - OP_W){1'b0}}, b_ld};
      end else if (state_q == RUN) begin
         p_q <= p_step;
         if (last_step) begin
            cnt_q     <= '0;
            product_q <= result;
         end else begin
            cnt_q <= cnt_q + 3'd1;
         end
      end
   end

   assign busy_o    = (state_q == RUN);
   assign done_o    = (state_q == DONE);
   assign product_o = product_q;

endmodule
